// File: rtl/ic_id_queue.sv
// Fetch-to-decode queue: DEPTH-entry FIFO of {PC, INST} feeding the ID output register; `IC_ID_BYPASS_EN adds an empty-queue bypass.
// Latency 1 cycle with bypass on an empty unstalled queue, otherwise 1 cycle after reaching the head; IN_READY low only when full.
module ic_id_queue #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [DATA_W-1:0]  NOP_INST = {DATA_W{1'b0}}
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         STALL_ID,
    input  logic                         FLUSH,
    input  logic                         IN_VALID,
    input  logic                         IN_IV,
    input  logic [ADDR_W-1:0]            IN_PC,
    input  logic [DATA_W-1:0]            IN_INST,
    output logic                         IN_READY,
    output logic                         ID_VALID,
    output logic [ADDR_W-1:0]            ID_PC,
    output logic [DATA_W-1:0]            ID_INST,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_nxt;

    logic              accept, empty, byp, enq, deq;
    logic              out_vld_nxt;
    logic [ADDR_W-1:0] out_pc_nxt;
    logic [DATA_W-1:0] out_inst_nxt;

    // Ready looks only at the registered count so fetch never sees a path through the dequeue logic.
    assign IN_READY = (COUNT < CW'(DEPTH));
    assign accept   = IN_VALID & IN_READY;
    assign empty    = (COUNT == '0);

`ifdef IC_ID_BYPASS_EN
    assign byp = empty & ~STALL_ID & accept;
`else
    assign byp = 1'b0;
`endif

    assign deq = ~STALL_ID & ~empty & ~FLUSH & ~RST;
    assign enq = accept & IN_IV & ~byp & ~FLUSH & ~RST;

    always_comb begin
        out_vld_nxt  = 1'b0;
        out_pc_nxt   = ID_PC;
        out_inst_nxt = NOP_INST;
        if (!empty) begin
            out_vld_nxt  = 1'b1;
            out_pc_nxt   = pc_mem[rd_ptr];
            out_inst_nxt = inst_mem[rd_ptr];
        end
`ifdef IC_ID_BYPASS_EN
        else if (byp) begin
            // A cancelled beat still surfaces as a bubble carrying its PC.
            out_vld_nxt  = IN_IV;
            out_pc_nxt   = IN_PC;
            out_inst_nxt = IN_IV ? IN_INST : NOP_INST;
        end
`endif
    end

    always_comb begin
        count_nxt = COUNT;
        case ({enq, deq})
            2'b10:   count_nxt = COUNT + CW'(1);
            2'b01:   count_nxt = COUNT - CW'(1);
            default: count_nxt = COUNT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            pc_mem[wr_ptr]   <= IN_PC;
            inst_mem[wr_ptr] <= IN_INST;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            ID_VALID <= 1'b0;
            ID_PC    <= '0;
            ID_INST  <= NOP_INST;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            COUNT <= count_nxt;
            if (!STALL_ID) begin
                ID_VALID <= out_vld_nxt;
                ID_PC    <= out_pc_nxt;
                ID_INST  <= out_inst_nxt;
            end
        end
    end
endmodule

// File: doc/ic_id_queue.md
# ic_id_queue

Parametrised fetch-to-decode boundary between the instruction cache stage and ID. It replaces the single-entry delay-slot holding register with a DEPTH-entry instruction queue feeding an output register. Instructions returned by the cache while decode is stalled are kept in order, and cancelled (IV low) fetches are squashed. A flush empties the whole structure in one cycle.

## Interface
- ADDR_W, 32, PC width
- DATA_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- NOP_INST, 32'h0000_0000, word presented to ID when no valid instruction is available
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- STALL_ID  in  1  ID stage stalled; output register holds
- FLUSH  in  1  branch/exception redirect; discard everything
- IN_VALID  in  1  cache returns an instruction this cycle
- IN_IV  in  1  instruction valid (0 = cancelled by redirect, squash)
- IN_PC  in  ADDR_W  PC of returned instruction
- IN_INST  in  DATA_W  returned instruction
- IN_READY  out  1  queue can accept; fetch must hold its return when low
- ID_VALID  out  1  ID_INST is a real instruction
- ID_PC  out  ADDR_W  PC to decode
- ID_INST  out  DATA_W  instruction to decode
- COUNT  out  $clog2(DEPTH+1)  current queue occupancy

## Operation
- Storage: circular queue of DEPTH {PC, INST} entries with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap naturally, a COUNT register, and an output register {ID_VALID, ID_PC, ID_INST}.
- IN_READY = (COUNT < DEPTH). It is based on the current count only; a same-cycle dequeue does not open a slot.
- Accept = IN_VALID & IN_READY. An IN_VALID with IN_READY low is ignored and fetch re-presents it.
- Squash: an accepted beat with IN_IV=0 is never enqueued.
- Output load (STALL_ID=0, FLUSH=0), priority order:
  1. Queue non-empty: load the head entry, ID_VALID=1, rd_ptr+1.
  2. Queue empty and bypass path taken (see Configuration): load the input. IN_IV=1 gives the instruction with ID_VALID=1. IN_IV=0 gives NOP_INST, IN_PC, ID_VALID=0.
  3. Otherwise: load NOP_INST, ID_PC holds, ID_VALID=0.
- Enqueue: an accepted IN_IV=1 beat not consumed by bypass is written at wr_ptr, and wr_ptr+1.
- Simultaneous enqueue and dequeue leaves COUNT unchanged and preserves order.
- STALL_ID=1: the output register holds all fields; enqueue continues until full.
- FLUSH (priority over STALL_ID and input):
  - Pointers and COUNT are set to 0.
  - Output register is set to NOP_INST, PC 0, ID_VALID=0.
  - The input beat in the flush cycle is dropped.
- Queue ordering is strictly FIFO. No reordering, and no duplication after a stall release.

## Timing
- Reset and flush values: ID_VALID=0, ID_PC=0, ID_INST=NOP_INST, COUNT=0, IN_READY=1. All are visible the cycle after RST/FLUSH is sampled high.
- RST mid-stall discards queue contents identically to FLUSH.
- Latency, IN_VALID to ID_INST:
  - 1 cycle with bypass on an empty, unstalled queue.
  - Otherwise 1 cycle after the instruction reaches the head while STALL_ID=0.
- Throughput: 1 instruction per cycle sustained when STALL_ID=0.
- Full boundary: at COUNT=DEPTH, IN_READY=0 combinationally in the same cycle. It returns to 1 the cycle after the first dequeue.
- Empty boundary: with COUNT=0, no bypass and STALL_ID=0, the next ID_VALID=0.
- COUNT never exceeds DEPTH and never underflows. Pointer wrap from DEPTH-1 to 0 is transparent.

## Configuration
- IC_ID_BYPASS_EN defined:
  - Empty queue + STALL_ID=0 + accepted beat loads directly into the output register (latency 1, nothing enqueued).
  - IN_IV=0 beats on this path produce a visible NOP bubble (ID_VALID=0, ID_PC=IN_PC).
- IC_ID_BYPASS_EN undefined:
  - Every accepted IN_IV=1 beat is enqueued first. Minimum latency is 2 cycles and steady-state throughput is unchanged.
  - IN_IV=0 beats are silently dropped with no bubble.
  - The input-to-output combinational path is removed.

## Test plan
- Reset: hold RST 2 cycles with IN_VALID=1 -> ID_VALID=0, ID_PC=0, ID_INST=NOP_INST, COUNT=0, IN_READY=1.
- Streaming (bypass on): PCs 0x100,0x104,0x108 with STALL_ID=0 -> the same PCs appear on ID_PC one cycle later each, COUNT stays 0.
- Stall fill (DEPTH=4): STALL_ID=1 for 6 cycles while presenting PCs 0x200..0x214.
  - Required: COUNT reaches 4 and IN_READY falls.
  - After release: ID_PC shows 0x200,0x204,0x208,0x20C in order, no duplicates.
  - 0x210 is re-presented and accepted after the first dequeue.
- Squash: a beat with IN_IV=0 and PC 0x300 arrives during a stall, queue holding 0x2F8 -> 0x300 is never output and COUNT increments only for valid beats. With bypass on an empty queue, the output is ID_VALID=0, ID_INST=NOP_INST, ID_PC=0x300.
- Flush: with COUNT=3 and STALL_ID=1, assert FLUSH alongside IN_VALID (PC 0x400) -> next cycle COUNT=0, ID_VALID=0, and 0x400 is never output.
- Wrap: run 10 stall/release cycles with DEPTH=4 so the pointers wrap twice -> output order matches input order exactly, and COUNT never exceeds 4.
